// File: rtl/bstep_window_decoder.sv
// bstep_window_decoder: rate decoder for the binary-step activation stream.
// Counts the ones over a window of WIN accepted samples. Each completed count
// is loaded into a one-deep valid/ready holding register.
// Optional feature: define BSTEP_DEC_MAJ_EN to add the Out_maj majority flag.
module bstep_window_decoder #(
  parameter int OUT_W = 5,
  parameter int WIN   = 31   // legal range 2 .. 2**OUT_W-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Clear,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic             In,
  output logic             Out_valid,
  input  logic             Out_ready,
`ifdef BSTEP_DEC_MAJ_EN
  output logic             Out_maj,
`endif
  output logic [OUT_W-1:0] Out
);

  localparam int IDX_W = (WIN > 2) ? $clog2(WIN) : 1;

  logic [OUT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] sum;
  logic             accept;
  logic             last;
  logic             done;

  // Handshake and window-end decode. Clear takes precedence over a sample
  // arriving in the same cycle, so that sample never completes a window.
  always_comb begin
    In_ready = ~Out_valid | Out_ready;
    accept   = In_valid & In_ready;
    last     = (idx == IDX_W'(WIN - 1));
    sum      = cnt + OUT_W'(In);
    done     = accept & last & ~Clear;
  end

  // Window accumulator. cnt + In is at most WIN, which is below 2**OUT_W, so
  // it cannot overflow. Stalled or idle cycles leave idx and cnt unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (Clear) begin
      cnt <= '0;
      idx <= '0;
    end else if (accept) begin
      if (last) begin
        cnt <= '0;
        idx <= '0;
      end else begin
        cnt <= sum;
        idx <= idx + 1'b1;
      end
    end
  end

  // Output holding register. A completing window reloads it even while the
  // previous result is being consumed, which keeps Out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      Out       <= '0;
      Out_valid <= 1'b0;
    end else if (done) begin
      Out       <= sum;
      Out_valid <= 1'b1;
    end else if (Out_valid && Out_ready) begin
      Out_valid <= 1'b0;
    end
  end

`ifdef BSTEP_DEC_MAJ_EN
  // Majority flag. It loads with Out, so it is stable for as long as Out is.
  always_ff @(posedge clk) begin
    if (rst)
      Out_maj <= 1'b0;
    else if (done)
      Out_maj <= (sum > OUT_W'(WIN / 2));
  end
`endif

endmodule
